// File: rtl/serial_chan_arb.sv
// serial_chan_arb: round-robin arbiter/sequencer for one shared
// loadable-counter serial buffer channel. Grants one of two requesters,
// loads the channel counter with the latched length, holds the channel
// until carry-out, and recovers via a watchdog if carry-out never arrives.
module serial_chan_arb #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned WD_LIMIT = 258
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             abort,
  input  logic             co,
  output logic             ld,
  output logic             en_cnt,
  output logic             en_tri,
  output logic [LEN_W-1:0] PI,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic             err
);

  localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    XFER = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        gnt_q;
  logic [WD_W-1:0]   wd_cnt;
  // prefer1: requester 1 wins the next tie (set when requester 0 was served last)
  logic              prefer1;

  logic              grant;
  logic              ptr_upd;
  logic [1:0]        win;

  // Next-state decode, arbitration winner and bookkeeping strobes
  always_comb begin
    state_d = state;
    grant   = 1'b0;
    ptr_upd = 1'b0;
    if (req0 && req1) win = prefer1 ? 2'b10 : 2'b01;
    else if (req1)    win = 2'b10;
    else              win = 2'b01;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          ptr_upd = 1'b1;
        end else begin
          state_d = XFER;
        end
      end
      XFER: begin
        // abort beats co beats watchdog
        if (abort) begin
          state_d = IDLE;
          ptr_upd = 1'b1;
        end else if (co) begin
          state_d = DONE;
        end else if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
          state_d = ERR;
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        ptr_upd = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched grant/length, watchdog and fairness pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      len_q   <= '0;
      gnt_q   <= '0;
      wd_cnt  <= '0;
      prefer1 <= 1'b0;
    end else begin
      state <= state_d;
      if (grant) begin
        gnt_q <= win;
        len_q <= win[1] ? len1 : len0;
      end
      if (state == LOAD)      wd_cnt <= '0;
      else if (state == XFER) wd_cnt <= wd_cnt + 1'b1;
      if (ptr_upd) prefer1 <= gnt_q[0];
    end
  end

  // Outputs decoded purely from registered state; no input-to-output path
  always_comb begin
    busy   = (state != IDLE);
    ld     = (state == LOAD);
    en_cnt = (state == XFER);
    en_tri = (state == XFER);
    PI     = (state == LOAD || state == XFER) ? len_q : '0;
    gnt    = busy ? gnt_q : 2'b00;
    done   = (state == DONE) ? gnt_q : 2'b00;
    err    = (state == ERR);
  end

endmodule

// File: tb/tb_serial_chan_arb.sv
// Directed bench for serial_chan_arb with a behavioural model of the
// inverted-preload up-counter channel driving co.
module tb_serial_chan_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, abort, co;
  logic [7:0] len0, len1, PI;
  logic       ld, en_cnt, en_tri, busy, err;
  logic [1:0] gnt, done;

  int checks = 0;
  int failures = 0;

  // channel model
  logic [7:0] cnt_m;
  logic       co_block;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld)          cnt_m <= ~PI;
    else if (en_cnt) cnt_m <= cnt_m + 8'd1;
  end
  assign co = en_cnt && (cnt_m == 8'hFF) && !co_block;

  serial_chan_arb #(.LEN_W(8), .WD_LIMIT(258)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .abort(abort), .co(co), .ld(ld), .en_cnt(en_cnt), .en_tri(en_tri), .PI(PI),
    .gnt(gnt), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // entered in the first XFER cycle; returns in the cycle after XFER
  task automatic run_xfer(input logic [7:0] pi_exp, output int n, output int co_at,
                          output bit err_seen, output bit done_seen, output bit pi_bad);
    n = 0; co_at = -1; err_seen = 0; done_seen = 0; pi_bad = 0;
    while (en_cnt === 1'b1 && n < 400) begin
      n++;
      if (co) co_at = n;
      if (err) err_seen = 1;
      if (done != 2'b00) done_seen = 1;
      if (PI !== pi_exp || en_tri !== 1'b1) pi_bad = 1;
      tick();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".gnt"}, gnt, 0);
    chk({tag, ".en"}, {ld, en_cnt, en_tri, err}, 0);
    chk({tag, ".PI"}, PI, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  int  n, co_at;
  bit  err_seen, done_seen, pi_bad;

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0; len0 = 0; len1 = 0; abort = 0; co_block = 0;
    tick(); tick();
    chk_idle("reset");
    rst = 1'b1;

    // single request, L=3
    req0 = 1; len0 = 3;
    tick();                               // cycle 1
    chk("s.ld", ld, 1); chk("s.gnt", gnt, 2'b01); chk("s.busy", busy, 1); chk("s.PI", PI, 3);
    tick();                               // cycle 2
    for (int c = 2; c <= 5; c++) begin
      chk("s.en_cnt", en_cnt, 1); chk("s.en_tri", en_tri, 1);
      chk("s.co", co, (c == 5) ? 1 : 0);
      tick();
    end
    chk("s.done", done, 2'b01); chk("s.en_off", en_cnt, 0);   // cycle 6
    req0 = 0;
    tick();
    chk("s.idle", busy, 0);               // cycle 7

    // reset to restore req0-first tie order
    rst = 0; tick(); rst = 1;

    // tie fairness, L=0
    req0 = 1; req1 = 1; len0 = 0; len1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t.gnt", gnt, (k % 2) ? 2'b10 : 2'b01); chk("t.ld", ld, 1);
      tick();
      chk("t.co", co, 1); chk("t.en", en_cnt, 1);
      tick();
      chk("t.done", done, (k % 2) ? 2'b10 : 2'b01); chk("t.busy_d", busy, 1);
      if (k == 3) begin req0 = 0; req1 = 0; end
      tick();
      chk("t.idle", busy, 0);
    end

    // L=255: 256-cycle window, no watchdog
    req1 = 1; len1 = 8'd255;
    tick();
    chk("x.gnt", gnt, 2'b10);
    tick();
    run_xfer(8'd255, n, co_at, err_seen, done_seen, pi_bad);
    chk("x.len", n, 256); chk("x.co_at", co_at, 256); chk("x.err", err_seen, 0);
    chk("x.pi", pi_bad, 0);
    chk("x.done", done, 2'b10); chk("x.err_end", err, 0);
    req1 = 0;
    tick();
    chk("x.idle", busy, 0);

    // watchdog: co suppressed
    co_block = 1; req1 = 1; len1 = 5;
    tick(); tick();
    run_xfer(8'd5, n, co_at, err_seen, done_seen, pi_bad);
    chk("w.len", n, 258); chk("w.err", err, 1); chk("w.done", done_seen, 0);
    chk("w.done_end", done, 0); chk("w.gnt", gnt, 2'b10);
    req1 = 0; co_block = 0;
    tick();
    chk("w.idle", busy, 0); chk("w.err_off", err, 0);

    // abort in 3rd XFER cycle
    req0 = 1; req1 = 1; len0 = 3; len1 = 3;
    tick();
    chk("a.gnt", gnt, 2'b01);
    tick(); tick(); tick();               // XFER cycle 3
    chk("a.xfer3", en_cnt, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("a.idle", busy, 0); chk("a.done", done, 0);
    tick();
    chk("a.next_gnt", gnt, 2'b10);
    tick(); tick();                       // XFER cycle 2
    rst = 0;
    tick();
    chk_idle("r");
    rst = 1;
    tick();
    chk("r.tie", gnt, 2'b01);

    // input stability: drop req, change len mid-window
    tick();
    req0 = 0; req1 = 0; len0 = 8'd9;
    run_xfer(8'd3, n, co_at, err_seen, done_seen, pi_bad);
    chk("i.len", n, 4); chk("i.pi", pi_bad, 0); chk("i.done", done, 2'b01);
    tick();
    chk("i.idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
